// File: rtl/conv33_window.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 register window,
// one pixel per handshake in row-major order, stride 1, no padding.
module conv33_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  pix_valid_in,
  output logic                  pix_ready_out,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  win_valid_out,
  input  logic                  win_ready_in,
  output logic [DATA_WIDTH-1:0] win_0_0,
  output logic [DATA_WIDTH-1:0] win_0_1,
  output logic [DATA_WIDTH-1:0] win_0_2,
  output logic [DATA_WIDTH-1:0] win_1_0,
  output logic [DATA_WIDTH-1:0] win_1_1,
  output logic [DATA_WIDTH-1:0] win_1_2,
  output logic [DATA_WIDTH-1:0] win_2_0,
  output logic [DATA_WIDTH-1:0] win_2_1,
  output logic [DATA_WIDTH-1:0] win_2_2
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         col_reg;
  logic [RW-1:0]         row_reg;
  logic                  last_taken_reg;
  logic                  win_valid_reg;
  logic                  accept;
  logic                  col_last, row_last;

  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] new_col [3];
  logic [DATA_WIDTH-1:0] win_tap [9];

  assign pix_ready_out = (state_reg == RUN) && !last_taken_reg &&
                         (!win_valid_reg || win_ready_in);
  assign accept        = pix_valid_in && pix_ready_out;
  assign col_last      = (col_reg == CW'(IMG_W - 1));
  assign row_last      = (row_reg == RW'(IMG_H - 1));
  assign done          = (state_reg == DONE);
  assign win_valid_out = win_valid_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      // Once the final pixel is in, the only window left is the last one.
      RUN:     if (last_taken_reg && win_valid_reg && win_ready_in) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      last_taken_reg <= 1'b0;
      win_valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        col_reg        <= '0;
        row_reg        <= '0;
        last_taken_reg <= 1'b0;
      end else if (accept) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + RW'(1);
          if (row_last) last_taken_reg <= 1'b1;
        end else begin
          col_reg <= col_reg + CW'(1);
        end
      end
      if (accept)
        win_valid_reg <= (row_reg >= RW'(2)) && (col_reg >= CW'(2));
      else if (win_ready_in)
        win_valid_reg <= 1'b0;
    end
  end

  // Line buffers are never cleared; rows 0-1 refill them each frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_reg] <= lb0[col_reg];
      lb0[col_reg] <= pix_data;
    end
  end

  assign new_col[0] = lb1[col_reg];
  assign new_col[1] = lb0[col_reg];
  assign new_col[2] = pix_data;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    logic [DATA_WIDTH-1:0] tap_reg [3];

    always_ff @(posedge clk) begin
      if (rst) begin
        tap_reg[0] <= '0;
        tap_reg[1] <= '0;
        tap_reg[2] <= '0;
      end else if (accept) begin
        tap_reg[0] <= tap_reg[1];
        tap_reg[1] <= tap_reg[2];
        tap_reg[2] <= new_col[gi];
      end
    end

    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign win_tap[gi*3 + gj] = tap_reg[gj];
    end
  end

  assign win_0_0 = win_tap[0];
  assign win_0_1 = win_tap[1];
  assign win_0_2 = win_tap[2];
  assign win_1_0 = win_tap[3];
  assign win_1_1 = win_tap[4];
  assign win_1_2 = win_tap[5];
  assign win_2_0 = win_tap[6];
  assign win_2_1 = win_tap[7];
  assign win_2_2 = win_tap[8];

endmodule

// File: tb/tb_conv33_window.sv
// Self-checking bench for conv33_window: three frame geometries (4x4, 5x4, 28x28)
// checked against a sliding-window scoreboard plus literal windows.
module tb_conv33_window;

  localparam int NDUT = 3;
  localparam int W_OF [NDUT] = '{4, 5, 28};
  localparam int H_OF [NDUT] = '{4, 4, 28};
  localparam int MAXPIX = 28 * 28;

  logic       clk = 1'b0;
  logic       rst [NDUT];
  logic       start [NDUT];
  logic       pix_valid [NDUT];
  logic       win_ready [NDUT];
  logic [7:0] pix_data [NDUT];
  logic       done_w [NDUT];
  logic       pix_ready [NDUT];
  logic       win_valid [NDUT];
  logic [7:0] win [NDUT][9];
  logic       sb_clear [NDUT];

  int          checks = 0;
  int          errors = 0;
  int          k [NDUT];
  int          done_cnt [NDUT];
  logic        done_due [NDUT];
  logic [7:0]  frame [NDUT][MAXPIX];
  logic [71:0] expq [NDUT][$];
  logic [71:0] hs_log [NDUT][$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    conv33_window #(.DATA_WIDTH(8), .IMG_W(W_OF[gi]), .IMG_H(H_OF[gi])) u_dut (
      .clk(clk), .rst(rst[gi]), .start(start[gi]), .done(done_w[gi]),
      .pix_valid_in(pix_valid[gi]), .pix_ready_out(pix_ready[gi]), .pix_data(pix_data[gi]),
      .win_valid_out(win_valid[gi]), .win_ready_in(win_ready[gi]),
      .win_0_0(win[gi][0]), .win_0_1(win[gi][1]), .win_0_2(win[gi][2]),
      .win_1_0(win[gi][3]), .win_1_1(win[gi][4]), .win_1_2(win[gi][5]),
      .win_2_0(win[gi][6]), .win_2_1(win[gi][7]), .win_2_2(win[gi][8])
    );
  end

  task automatic chk(input string nm, input int d, input logic [71:0] got, input logic [71:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, got, want, $time);
    end
  endtask

  function automatic logic [71:0] pack_win(input int d);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], win[d][i]};
    return v;
  endfunction

  task automatic chk_reset(input int d);
    chk("rst_pix_ready", d, 72'(pix_ready[d]), 72'(0));
    chk("rst_win_valid", d, 72'(win_valid[d]), 72'(0));
    chk("rst_done", d, 72'(done_w[d]), 72'(0));
    chk("rst_window", d, pack_win(d), 72'(0));
  endtask

  // Scoreboard: every accepted pixel is stored at its (row,col); a window is
  // owed for each accept with row>=2 and col>=2, and consumed on handshake.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      int w, total, r, c;
      logic [71:0] got, exp_w;
      w = W_OF[d];
      total = W_OF[d] * H_OF[d];
      got = pack_win(d);
      if (rst[d] || sb_clear[d]) begin
        if (sb_clear[d]) begin
          hs_log[d].delete();
          done_cnt[d] = 0;
        end
        k[d] = 0;
        expq[d].delete();
        done_due[d] = 1'b0;
      end else begin
        chk("done", d, 72'(done_w[d]), 72'(done_due[d]));
        if (done_w[d]) done_cnt[d]++;
        done_due[d] = 1'b0;
        chk("win_valid", d, 72'(win_valid[d]), 72'(expq[d].size() > 0));
        if (win_valid[d] && expq[d].size() > 0) begin
          chk("window", d, got, expq[d][0]);
          if (win_ready[d]) begin
            hs_log[d].push_back(got);
            void'(expq[d].pop_front());
            done_due[d] = (k[d] == total) && (expq[d].size() == 0);
          end else begin
            chk("stall_ready", d, 72'(pix_ready[d]), 72'(0));
          end
        end
        if (k[d] == total) chk("last_ready", d, 72'(pix_ready[d]), 72'(0));
        if (pix_valid[d] && pix_ready[d] && k[d] < total) begin
          r = k[d] / w;
          c = k[d] % w;
          frame[d][k[d]] = pix_data[d];
          if (r >= 2 && c >= 2) begin
            exp_w = '0;
            for (int rr = 0; rr < 3; rr++)
              for (int cc = 0; cc < 3; cc++)
                exp_w = {exp_w[63:0], frame[d][(r - 2 + rr) * w + (c - 2 + cc)]};
            expq[d].push_back(exp_w);
          end
          k[d]++;
        end
      end
    end
  end

  // Drives one frame; returns early after abort_at accepts (if >= 0).
  task automatic run_frame(input int d, input int base, input int vpct, input int rpct,
                           input bit rand_pix, input int abort_at, input int bp_hold,
                           input int stray_at);
    int p, total, hold;
    bit acc, dn, bp_done, finished;
    logic [7:0] cur;
    total = W_OF[d] * H_OF[d];
    // Pixels offered while idle must be ignored.
    pix_valid[d] = 1'b1;
    pix_data[d] = 8'hEE;
    repeat (2) begin @(posedge clk); #1; end
    pix_valid[d] = 1'b0;
    start[d] = 1'b1;
    sb_clear[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    sb_clear[d] = 1'b0;
    p = 0;
    hold = 0;
    bp_done = 1'b0;
    finished = 1'b0;
    cur = rand_pix ? 8'($urandom) : 8'(base);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (abort_at >= 0 && p >= abort_at) begin
        finished = 1'b1;
        break;
      end
      if (bp_hold > 0 && !bp_done && win_valid[d]) begin
        hold = bp_hold;
        bp_done = 1'b1;
      end
      pix_valid[d] = (p < total) && ($urandom_range(99) < 32'(vpct));
      pix_data[d] = cur;
      start[d] = (p == stray_at);
      if (hold > 0) begin
        win_ready[d] = 1'b0;
        hold--;
      end else begin
        win_ready[d] = ($urandom_range(99) < 32'(rpct));
      end
      @(negedge clk);
      acc = pix_valid[d] && pix_ready[d];
      dn = done_w[d];
      @(posedge clk); #1;
      if (acc) begin
        p++;
        cur = rand_pix ? 8'($urandom) : 8'(base + p);
      end
      if (dn) begin
        finished = 1'b1;
        break;
      end
    end
    pix_valid[d] = 1'b0;
    win_ready[d] = 1'b0;
    start[d] = 1'b0;
    if (!finished) chk("timeout", d, 72'(0), 72'(1));
  endtask

  task automatic chk_4x4_frame(input logic [71:0] base);
    chk("n_windows", 0, 72'(hs_log[0].size()), 72'(4));
    chk("done_pulses", 0, 72'(done_cnt[0]), 72'(1));
    if (hs_log[0].size() == 4) begin
      chk("win0", 0, hs_log[0][0], 72'h00_01_02_04_05_06_08_09_0A + base);
      chk("win1", 0, hs_log[0][1], 72'h01_02_03_05_06_07_09_0A_0B + base);
      chk("win2", 0, hs_log[0][2], 72'h04_05_06_08_09_0A_0C_0D_0E + base);
      chk("win3", 0, hs_log[0][3], 72'h05_06_07_09_0A_0B_0D_0E_0F + base);
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1;
      start[d] = 1'b0;
      pix_valid[d] = 1'b0;
      win_ready[d] = 1'b0;
      pix_data[d] = '0;
      sb_clear[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk_reset(d);

    // 4x4, pixels 0..15, ready always high.
    run_frame(0, 0, 100, 100, 1'b0, -1, 0, -1);
    chk_4x4_frame(72'h0);

    // 4x4 with the first window held for 5 cycles.
    run_frame(0, 0, 100, 100, 1'b0, -1, 5, -1);
    chk_4x4_frame(72'h0);

    // 5x4 with random bubbles on both sides and random pixel values.
    run_frame(1, 0, 50, 50, 1'b1, -1, 0, -1);
    chk("n_windows", 1, 72'(hs_log[1].size()), 72'(6));
    chk("done_pulses", 1, 72'(done_cnt[1]), 72'(1));
    run_frame(1, 0, 70, 30, 1'b1, -1, 0, -1);
    chk("n_windows", 1, 72'(hs_log[1].size()), 72'(6));

    // Reset after 7 pixels, then a clean frame of 100..115.
    run_frame(0, 0, 100, 100, 1'b0, 7, 0, -1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk_reset(0);
    run_frame(0, 100, 100, 100, 1'b0, -1, 0, -1);
    chk_4x4_frame(72'h64_64_64_64_64_64_64_64_64);

    // 28x28, pixel = p mod 256, stray start pulse mid-frame.
    run_frame(2, 0, 90, 90, 1'b0, -1, 0, 100);
    chk("n_windows", 2, 72'(hs_log[2].size()), 72'(676));
    chk("done_pulses", 2, 72'(done_cnt[2]), 72'(1));
    if (hs_log[2].size() > 0)
      chk("last_win", 2, hs_log[2][hs_log[2].size() - 1], 72'hD5_D6_D7_F1_F2_F3_0D_0E_0F);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv33_window.md
# conv33_window

Line-buffer window generator directly upstream of the 3×3 convolution core. It accepts one feature-map pixel per handshake in row-major order and keeps the two previous rows in on-chip line buffers. For every valid stride-1, no-padding position it presents a complete 3×3 window on nine parallel outputs. The window valid/ready pair and the nine window outputs wire one-to-one onto the core's input valid/ready and its nine window inputs.

## Interface
- DATA_WIDTH, 8: pixel width.
- IMG_W, 28: feature-map width in pixels. Must be ≥ 3.
- IMG_H, 28: feature-map height in pixels. Must be ≥ 3.

- clk  input  1: single clock, rising edge.
- rst  input  1: synchronous, active-high reset.
- start  input  1: begin one frame. Sampled only in IDLE.
- done  output  1: one-cycle pulse when the frame is complete.
- pix_valid_in  input  1: pixel available on pix_data.
- pix_ready_out  output  1: block can accept a pixel.
- pix_data  input  DATA_WIDTH: pixel value.
- win_valid_out  output  1: window outputs hold a valid window.
- win_ready_in  input  1: downstream consumes the window.
- win_0_0 … win_2_2  output  DATA_WIDTH each (9 ports): window element at row r, column c. Row 0 is the oldest row (top), column 0 is leftmost, and win_2_2 is the most recently accepted pixel.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on start. This transition clears the col and row counters.
  - RUN → DONE once the last pixel (row IMG_H-1, col IMG_W-1) has been accepted and its window has been handshaken.
  - DONE → IDLE unconditionally after one cycle. done = 1 only while in DONE.
- Counters are col, width $clog2(IMG_W), and row, width $clog2(IMG_H).
  - col increments on each accept and wraps from IMG_W-1 to 0.
  - row increments on each col wrap.
- pix_ready_out = (state == RUN) && !last_taken && (!win_valid_out || win_ready_in).
  - last_taken is set when the final pixel is accepted and cleared on start.
- accept = pix_valid_in && pix_ready_out. On accept:
  - Line buffers: lb1[col] ← lb0[col], then lb0[col] ← pix_data. lb0 holds row-1 and lb1 holds row-2; each is an IMG_W-deep register or RAM array.
  - Window: every row shifts left by one column, i.e. win_r_0 ← win_r_1 and win_r_1 ← win_r_2.
  - New right column: win_0_2 ← lb1[col], win_1_2 ← lb0[col], win_2_2 ← pix_data. These read the pre-update buffer values.
- win_valid_out update rule:
  - On accept, win_valid_out ← (row ≥ 2 && col ≥ 2).
  - Otherwise, if win_ready_in is high, win_valid_out ← 0.
- Output count per frame is (IMG_W-2)·(IMG_H-2) windows. The window for an accept at (r,c) has centre (r-1,c-1).
- Line buffer contents are never cleared. Rows 0–1 of every frame overwrite them before any valid window reads them.

## Timing
- Reset values: state IDLE, done 0, pix_ready_out 0, win_valid_out 0, all win_* 0, counters 0, last_taken 0.
- Latency: win_valid_out and the window data appear on the cycle after the accept of pixel (r,c).
- Throughput: one pixel per cycle while pix_valid_in and win_ready_in are both held high.
- Backpressure: while win_valid_out && !win_ready_in, pix_ready_out = 0 and all win_* outputs are held stable.
- Simultaneous window handshake and new accept in the same cycle: the new window replaces the old one with no bubble.
- Row-start columns 0 and 1 shift in without raising win_valid_out. Stale columns from the previous row are shifted out before col = 2.
- start outside IDLE is ignored. pix_valid_in outside RUN is ignored.
- done rises on the cycle after the final window's handshake cycle and lasts exactly one cycle.
- rst during RUN aborts the frame. The next start begins a clean frame with no stale windows emitted.

## Test plan
- IMG_W = IMG_H = 4, pixels 0..15, ready held high.
  - Exactly 4 windows: {0,1,2/4,5,6/8,9,10}, {1,2,3/5,6,7/9,10,11}, {4,5,6/8,9,10/12,13,14}, {5,6,7/9,10,11/13,14,15}.
  - First window valid on the cycle after pixel 10 is accepted.
  - done pulses once, one cycle after the last window handshake.
- Backpressure, 4×4 frame: hold win_ready_in low for 5 cycles while the first window is valid.
  - pix_ready_out stays 0 for those cycles.
  - Window stays {0,1,2/4,5,6/8,9,10}.
  - No pixel is lost; the remaining 3 windows match the first scenario.
- Random pix_valid_in bubbles (~50%) plus random win_ready_in on a 5×4 frame.
  - Output is 6 windows, identical in order and value to a software 3×3 sliding reference.
- Reset mid-frame: after 7 pixels of a 4×4 frame, pulse rst.
  - All outputs return to reset values.
  - A new start with pixels 100..115 yields 4 windows, the first being {100,101,102/104,105,106/108,109,110}.
- Default 28×28, pixel = (row·28 + col) mod 256.
  - 676 windows, last window centred at (26,26).
  - A start pulse during RUN has no effect.
  - Exactly one done pulse.
